// File: rtl/vend_dispense_ctrl.sv
// Vending dispense sequencer: coin credit accumulation, motor dispense,
// greedy change payout over a request/acknowledge handshake, cancel and
// inactivity refund.
//
// state  | meaning
// IDLE   | no credit, waiting for the first coin
// CREDIT | credit held, waiting for price, cancel or timeout
// VEND   | motor running, waiting for motor_done
// CHANGE | paying out remaining credit one coin per handshake
// DONE   | one-cycle wrap-up before returning to IDLE
module vend_dispense_ctrl #(
  parameter int PRICE   = 20,
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       coin_valid,
  input  logic [1:0] coin_val,
  input  logic       cancel,
  input  logic       motor_done,
  input  logic       coin_ack,
  output logic [4:0] credit,
  output logic       coin_reject,
  output logic       motor_req,
  output logic       coin_req,
  output logic [1:0] coin_type,
  output logic       vend,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, CREDIT, VEND, CHANGE, DONE} state_t;

  localparam logic [4:0] PRICE_C   = 5'(PRICE);
  localparam logic [5:0] TIMEOUT_C = 6'(TIMEOUT);

  state_t     state, state_nx;
  logic [4:0] remaining, remaining_nx;
  logic [5:0] timer, timer_nx, timer_inc;
  logic [4:0] credit_nx;
  logic       coin_reject_nx, coin_req_nx;
  logic [1:0] coin_type_nx;
  logic       coin_present;

  function automatic logic [4:0] coin_cents(input logic [1:0] c);
    case (c)
      2'b01:   return 5'd1;
      2'b10:   return 5'd5;
      2'b11:   return 5'd10;
      default: return 5'd0;
    endcase
  endfunction

  // Largest denomination that still fits in the amount owed.
  function automatic logic [1:0] pick_denom(input logic [4:0] r);
    if (r >= 5'd10)     return 2'b11;
    else if (r >= 5'd5) return 2'b10;
    else                return 2'b01;
  endfunction

  assign coin_present = coin_valid && (coin_val != 2'b00);
  assign timer_inc    = timer + {5'd0, tick};

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_nx       = state;
    credit_nx      = credit;
    remaining_nx   = remaining;
    timer_nx       = 6'd0;
    coin_reject_nx = 1'b0;
    coin_req_nx    = 1'b0;
    coin_type_nx   = 2'b00;
    case (state)
      IDLE: begin
        if (coin_present) begin
          if (cancel) begin
            coin_reject_nx = 1'b1;
          end else begin
            credit_nx = credit + coin_cents(coin_val);
            state_nx  = CREDIT;
          end
        end
      end
      CREDIT: begin
        // A coin arriving while the price is already met would overflow
        // the credit register, so it is bounced.
        if (credit >= PRICE_C) begin
          state_nx       = VEND;
          remaining_nx   = credit - PRICE_C;
          credit_nx      = 5'd0;
          coin_reject_nx = coin_present;
        end else if (coin_present && !cancel) begin
          credit_nx = credit + coin_cents(coin_val);
        end else if (cancel) begin
          coin_reject_nx = coin_present;
          state_nx       = CHANGE;
          remaining_nx   = credit;
        end else if (timer_inc == TIMEOUT_C) begin
          state_nx     = CHANGE;
          remaining_nx = credit;
        end else begin
          timer_nx = timer_inc;
        end
      end
      VEND: begin
        coin_reject_nx = coin_present;
        if (motor_done) begin
          state_nx = (remaining != 5'd0) ? CHANGE : DONE;
        end
      end
      CHANGE: begin
        coin_reject_nx = coin_present;
        if (coin_req && coin_ack) begin
          remaining_nx = remaining - coin_cents(coin_type);
        end else if (coin_req) begin
          coin_req_nx  = 1'b1;
          coin_type_nx = coin_type;
        end else if (remaining == 5'd0) begin
          state_nx = DONE;
        end else begin
          coin_req_nx  = 1'b1;
          coin_type_nx = pick_denom(remaining);
        end
      end
      DONE: begin
        coin_reject_nx = coin_present;
        state_nx       = IDLE;
        credit_nx      = 5'd0;
      end
      default: state_nx = IDLE;
    endcase
    // First request is raised on the same edge that enters CHANGE.
    if (state_nx == CHANGE && state != CHANGE) begin
      coin_req_nx  = 1'b1;
      coin_type_nx = pick_denom(remaining_nx);
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= 5'd0;
      remaining   <= 5'd0;
      timer       <= 6'd0;
      coin_reject <= 1'b0;
      motor_req   <= 1'b0;
      coin_req    <= 1'b0;
      coin_type   <= 2'b00;
      vend        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      credit      <= credit_nx;
      remaining   <= remaining_nx;
      timer       <= timer_nx;
      coin_reject <= coin_reject_nx;
      motor_req   <= (state_nx == VEND);
      coin_req    <= coin_req_nx;
      coin_type   <= coin_type_nx;
      vend        <= (state_nx == VEND) && (state != VEND);
      busy        <= (state_nx == VEND) || (state_nx == CHANGE) || (state_nx == DONE);
    end
  end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
Sequencing controller for the vending datapath. It accepts validated coin pulses, accumulates credit, and starts the dispense motor once credit reaches PRICE. It then pays out change one coin at a time over a request/acknowledge handshake, largest denomination first. It also handles cancel requests and refunds credit after an inactivity timeout driven by the slow tick from the clock divider.

Parameters:
PRICE, 20, item price in cents; legal range 1..22 so that credit never exceeds 31.
TIMEOUT, 30, number of tick pulses with no accepted coin before credit is refunded; legal range 1..63.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle pulse from the clock divider (nominally 1 Hz)
coin_valid  in  1  one-cycle pulse; a coin is presented
coin_val  in  2  01=penny(1), 10=nickel(5), 11=dime(10), 00=ignored
cancel  in  1  one-cycle pulse; refund all credit
motor_done  in  1  dispense motor finished; level, sampled in VEND only
coin_ack  in  1  change hopper accepted the current coin request
credit  out  5  current credit in cents
coin_reject  out  1  one-cycle pulse; the presented coin was not accepted
motor_req  out  1  held high for the whole of VEND
coin_req  out  1  change coin request; held until acknowledged
coin_type  out  2  denomination of the coin being requested, same encoding as coin_val
vend  out  1  one-cycle pulse on entry to VEND
busy  out  1  high in VEND, CHANGE and DONE

Behaviour:
- Reset: state=IDLE. credit=0, remaining=0, timer=0. All outputs 0.
- rst wins over every other input, including mid-VEND or mid-CHANGE. Credit is discarded and motor_req/coin_req drop on the next edge.
- States: IDLE, CREDIT, VEND, CHANGE, DONE. State, credit and all outputs are registered.
- Coin accept:
  - Legal only in IDLE or CREDIT, with coin_val≠00 and no cancel in the same cycle.
  - credit ← credit+value at the next edge, and state ← CREDIT.
  - coin_valid with coin_val=00 is ignored; no reject.
  - coin_valid in VEND, CHANGE or DONE, or together with cancel → coin_reject=1 for one cycle, credit unchanged.
- CREDIT:
  - If credit ≥ PRICE → VEND at the next edge, remaining ← credit−PRICE, vend pulses for one cycle.
  - Else if cancel → CHANGE with remaining ← credit (refund).
  - Else if timer reaches TIMEOUT → CHANGE with remaining ← credit (refund).
  - The price check takes priority over cancel and timeout once credit is registered.
- Timer:
  - 6 bits; increments on tick while in CREDIT.
  - Clears on an accepted coin and on leaving CREDIT.
  - Held at 0 outside CREDIT.
  - Compare is timer==TIMEOUT, evaluated after the increment.
- cancel in IDLE: no effect.
- VEND:
  - motor_req=1; credit reads 0 from VEND entry onward.
  - Wait for motor_done=1, then → CHANGE if remaining>0, else → DONE. No timeout on motor_done.
- CHANGE, greedy payout:
  - coin_type = dime if remaining≥10, else nickel if ≥5, else penny. coin_req=1.
  - On an edge where coin_req & coin_ack: remaining ← remaining−value and coin_req drops for one cycle (one coin per handshake).
  - Then reissue, or → DONE when remaining=0.
  - coin_type is stable while coin_req=1.
  - coin_ack while coin_req=0 is ignored.
- DONE: one cycle, busy=1, then → IDLE with credit=0.
- Entering CHANGE with remaining=0 cannot occur; VEND goes directly to DONE in that case.
- Width: the largest reachable credit is (PRICE−1)+10, so 5 bits is sufficient. No saturation logic.

Test Plan:
- rst; dime, dime → credit 10 then 20; vend pulse one cycle later. motor_req high until motor_done. No coin_req; DONE → IDLE; credit 0.
- Credit 19 (dime, nickel, 4 pennies), then dime → credit 29, VEND. After motor_done: one nickel request, then 4 penny requests, each completed by coin_ack. remaining reaches 0, then IDLE.
- Credit 7, then cancel → CHANGE. Nickel request, then 2 pennies; vend never asserted, motor_req never asserted.
- Credit 3, then 30 tick pulses with no coin → refund of 3 pennies. A coin accepted at tick 29 clears the timer, so no refund occurs at tick 30.
- Coin presented during VEND, and coin presented together with cancel in CREDIT → coin_reject pulses, credit unchanged.
- rst asserted mid-CHANGE with coin_req high → next edge: state IDLE, coin_req 0, credit 0; a subsequent coin_ack is ignored.
